// File: rtl/sobel_pkg.sv
// Shared types and default geometry for the sobel pipeline and its frame controller.
package sobel_pkg;
  localparam int ROW_WIDTH_DEF  = 720;
  localparam int COL_HEIGHT_DEF = 540;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int POS_W          = 10;   // enough for dimensions up to 1023
  localparam int FCNT_W         = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_state_t;
endpackage

// File: rtl/sobel_frame_ctrl_if.sv
// FIFO-side handshake: sobel result FIFO (pop side) and output FIFO (push side).
interface sobel_frame_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_rd_en;
  logic                  in_empty;
  logic [DATA_WIDTH-1:0] in_dout;
  logic                  out_wr_en;
  logic                  out_full;
  logic [DATA_WIDTH-1:0] out_din;

  modport master (
    output in_rd_en, out_wr_en, out_din,
    input  in_empty, in_dout, out_full
  );

  modport slave (
    input  in_rd_en, out_wr_en, out_din,
    output in_empty, in_dout, out_full
  );
endinterface

// File: rtl/sobel_frame_ctrl_raster_counter.sv
// Column/row raster position with border and last-pixel decode.
module raster_counter
  import sobel_pkg::*;
#(
  parameter int ROW_WIDTH  = ROW_WIDTH_DEF,
  parameter int COL_HEIGHT = COL_HEIGHT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic adv,
  output logic border,
  output logic last
);
  localparam logic [POS_W-1:0] LAST_COL = POS_W'(ROW_WIDTH - 1);
  localparam logic [POS_W-1:0] LAST_ROW = POS_W'(COL_HEIGHT - 1);

  logic [POS_W-1:0] col, row;
  logic             col_end, row_end;

  assign col_end = (col == LAST_COL);
  assign row_end = (row == LAST_ROW);
  assign border  = (row == '0) || row_end || (col == '0) || col_end;
  assign last    = col_end && row_end;

  // Wrapping at the last pixel leaves the counter at (0,0) for the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (adv) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end
endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frames sobel results with a zero border and streams the raster into the output FIFO.
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int ROW_WIDTH  = ROW_WIDTH_DEF,
  parameter int COL_HEIGHT = COL_HEIGHT_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  sobel_frame_ctrl_if.master bus,
  output logic              frame_start,
  output logic              frame_done,
  output logic              busy,
  output logic [FCNT_W-1:0] frame_count
);
  ctrl_state_t state;
  logic        border, last, run;

  assign run = (state == RUN);

  // Border pixels never touch the input FIFO; interior pixels pass through with no latency.
  always_comb begin
    bus.in_rd_en  = 1'b0;
    bus.out_wr_en = 1'b0;
    bus.out_din   = {DATA_WIDTH{1'b0}};
    if (run && !bus.out_full) begin
      if (border) begin
        bus.out_wr_en = 1'b1;
      end else if (!bus.in_empty) begin
        bus.in_rd_en  = 1'b1;
        bus.out_wr_en = 1'b1;
        bus.out_din   = bus.in_dout;
      end
    end
  end

  raster_counter #(
    .ROW_WIDTH (ROW_WIDTH),
    .COL_HEIGHT(COL_HEIGHT)
  ) u_raster (
    .clk   (clk),
    .reset (reset),
    .adv   (bus.out_wr_en),
    .border(border),
    .last  (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      case (state)
        IDLE: if (!bus.in_empty) begin
          state       <= RUN;
          busy        <= 1'b1;
          frame_start <= 1'b1;
        end
        RUN: if (bus.out_wr_en && last) state <= DONE;
        DONE: begin
          state       <= IDLE;
          busy        <= 1'b0;
          frame_done  <= 1'b1;
          frame_count <= frame_count + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl on a 4x4 frame with a modelled FWFT input FIFO.
module tb_sobel_frame_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start, frame_done, busy;
  logic [15:0] frame_count;

  sobel_frame_ctrl_if #(.DATA_WIDTH(8)) bus ();

  sobel_frame_ctrl #(
    .ROW_WIDTH (4),
    .COL_HEIGHT(4),
    .DATA_WIDTH(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .frame_start(frame_start),
    .frame_done (frame_done),
    .busy       (busy),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Input FIFO model: the initial block pushes, the DUT pops.
  logic [7:0] fmem [0:63];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       full_drv = 1'b0;
  assign bus.in_empty = (rd_ptr == wr_ptr);
  assign bus.in_dout  = fmem[rd_ptr[5:0]];
  assign bus.out_full = full_drv;
  always @(posedge clk) if (bus.in_rd_en) rd_ptr <= rd_ptr + 1;

  // Output capture and event counters.
  logic [7:0] cap    [0:255];
  int         capcyc [0:255];
  int         ncap = 0, ns = 0, nd = 0, npop = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!reset && bus.out_wr_en) begin
      cap[ncap]    = bus.out_din;
      capcyc[ncap] = cyc;
      ncap++;
    end
    if (frame_start) ns++;
    if (frame_done) nd++;
    if (bus.in_rd_en) npop++;
  end

  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    fmem[wr_ptr[5:0]] = v;
    wr_ptr++;
  endtask

  task automatic wait_writes(input string tag, input int target, input int bound);
    int n = 0;
    while (ncap < target && n < bound) begin
      @(posedge clk); #1; n++;
    end
    check(tag, 32'(ncap >= target), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int target, input int bound);
    int n = 0;
    while (nd < target && n < bound) begin
      @(posedge clk); #1; n++;
    end
    check(tag, 32'(nd >= target), 32'd1);
  endtask

  task automatic check_frame(input string tag, input int base,
                             input logic [7:0] a, b, c, d);
    logic [7:0] iv [4];
    logic [7:0] exp;
    iv = '{a, b, c, d};
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) begin
        exp = (r == 0 || r == 3 || k == 0 || k == 3) ? 8'd0 : iv[(r-1)*2 + (k-1)];
        check($sformatf("%s_px%0d", tag, r*4+k), 32'(cap[base + r*4 + k]), 32'(exp));
      end
  endtask

  initial begin
    int base, nd0, pop0, zeros, dn, n;
    logic seen;

    // Reset state
    #12;
    check("rst_wr_en", 32'(bus.out_wr_en), 0);
    check("rst_rd_en", 32'(bus.in_rd_en), 0);
    check("rst_din", 32'(bus.out_din), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_fcnt", 32'(frame_count), 0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;

    // Plain frame
    push(10); push(20); push(30); push(40);
    wait_done("t1_done", 1, 100);
    check("t1_nwr", ncap, 16);
    check_frame("t1", 0, 10, 20, 30, 40);
    check("t1_consec", 32'(capcyc[15] - capcyc[0]), 15);
    check("t1_starts", ns, 1);
    check("t1_dones", nd, 1);
    check("t1_pops", npop, 4);
    check("t1_fcnt", 32'(frame_count), 1);

    // Output FIFO full for 3 cycles at (1,1)
    base = ncap;
    push(10); push(20); push(30); push(40);
    wait_writes("t2_reach", base + 5, 100);
    pop0 = npop;
    full_drv = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t2_stall_wr", 32'(bus.out_wr_en), 0);
      check("t2_stall_rd", 32'(bus.in_rd_en), 0);
      check("t2_stall_din", 32'(bus.out_din), 0);
    end
    @(posedge clk); #1 full_drv = 1'b0;
    check("t2_nopop", npop, pop0);
    check("t2_held", ncap, base + 5);
    wait_done("t2_done", 2, 100);
    check("t2_nwr", ncap, base + 16);
    check_frame("t2", base, 10, 20, 30, 40);
    check("t2_fcnt", 32'(frame_count), 2);

    // Input FIFO empty at (2,1)
    base = ncap;
    push(10); push(20);
    wait_writes("t3_reach", base + 9, 100);
    repeat (5) begin
      @(negedge clk);
      check("t3_hold_wr", 32'(bus.out_wr_en), 0);
      check("t3_hold_busy", 32'(busy), 1);
    end
    check("t3_held", ncap, base + 9);
    push(30); push(40);
    wait_done("t3_done", 3, 100);
    check("t3_nwr", ncap, base + 16);
    check_frame("t3", base, 10, 20, 30, 40);
    check("t3_fcnt", 32'(frame_count), 3);

    // Reset mid-frame after 7 writes
    base = ncap;
    push(10); push(20); push(30); push(40);
    wait_writes("t4_reach", base + 7, 100);
    nd0 = nd;
    reset = 1'b1;
    #1;
    check("t4_rst_wr", 32'(bus.out_wr_en), 0);
    check("t4_rst_rd", 32'(bus.in_rd_en), 0);
    check("t4_rst_din", 32'(bus.out_din), 0);
    check("t4_rst_busy", 32'(busy), 0);
    check("t4_rst_fcnt", 32'(frame_count), 0);
    @(posedge clk); #1 reset = 1'b0;
    push(50); push(60);
    wait_done("t4_done", nd0 + 1, 100);
    check("t4_nwr", ncap, base + 7 + 16);
    check_frame("t4", base + 7, 30, 40, 50, 60);
    check("t4_starts", ns, 5);
    check("t4_dones", nd, nd0 + 1);
    check("t4_fcnt", 32'(frame_count), 1);

    // Back-to-back frames: busy drops for exactly one cycle between them
    base = ncap;
    for (int i = 1; i <= 8; i++) push(8'(i));
    seen = 1'b0; zeros = 0; dn = 0; n = 0;
    while (dn < 2 && n < 200) begin
      @(posedge clk); #1; n++;
      if (busy) seen = 1'b1;
      if (frame_done) dn++;
      if (seen && !busy && dn < 2) zeros++;
    end
    check("t5_frames", dn, 2);
    check("t5_nwr", ncap, base + 32);
    check_frame("t5a", base, 1, 2, 3, 4);
    check_frame("t5b", base + 16, 5, 6, 7, 8);
    check("t5_gap", zeros, 1);
    check("t5_fcnt", 32'(frame_count), 3);

    // frame_count wrap
    @(posedge clk); #1;
    force dut.frame_count = 16'hFFFF;
    #1 release dut.frame_count;
    nd0 = nd;
    push(7); push(8); push(9); push(11);
    wait_done("t6_done", nd0 + 1, 100);
    check_frame("t6", ncap - 16, 7, 8, 9, 11);
    check("t6_fcnt_wrap", 32'(frame_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
